// File: rtl/mem_fill_pkg.sv
// Shared definitions for the memory fill engine.
//   state_e   : controller states (IDLE, FILL, DONE)
//   MODE_*    : fill pattern select encodings
package mem_fill_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [MODE_W-1:0] MODE_IDENT = 2'b00;
  localparam logic [MODE_W-1:0] MODE_DESC  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_CONST = 2'b10;
  localparam logic [MODE_W-1:0] MODE_XOR   = 2'b11;

endpackage

// File: rtl/mem_fill_pat.sv
// Combinational fill-pattern generator.
//   addr     in  : current write address
//   mode     in  : pattern select (MODE_*)
//   fill_val in  : constant / XOR operand
//   wrdata   out : pattern word, truncated or zero-extended to DATA_W
module mem_fill_pat
  import mem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [MODE_W-1:0] mode,
  input  logic [DATA_W-1:0] fill_val,
  output logic [DATA_W-1:0] wrdata
);

  // DEPTH-1-addr is the bitwise inverse of addr; invert at ADDR_W before resizing
  // so zero-extension does not pull in inverted upper bits.
  logic [ADDR_W-1:0] addr_inv;
  assign addr_inv = ~addr;

  always_comb begin
    wrdata = '0;
    case (mode)
      MODE_IDENT: wrdata = DATA_W'(addr);
      MODE_DESC:  wrdata = DATA_W'(addr_inv);
      MODE_CONST: wrdata = fill_val;
      MODE_XOR:   wrdata = DATA_W'(addr) ^ fill_val;
      default:    wrdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_fill.sv
// Memory fill engine: on a start request writes all 2**ADDR_W words with a
// selected pattern, one word per unstalled cycle, then pulses done.
//   clk, rst       : clock, asynchronous active-high reset
//   en             : start request, accepted only while rdy
//   mode, fill_val : pattern select and operand, latched with en
//   stall          : memory port busy, suspends writes
//   rdy            : idle, ready for en
//   done           : one-cycle pulse after the final write
//   addr, wrdata   : write address and data
//   wren           : write strobe
module mem_fill
  import mem_fill_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              stall,
  output logic              rdy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [MODE_W-1:0] mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] pat_data;
  logic              in_fill;

  // Controller: state, write counter and latched request parameters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_IDENT;
      fill_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            mode_q  <= mode;
            fill_q  <= fill_val;
            cnt_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          // Counter only advances on cycles that actually write.
          if (!stall) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= DONE;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_fill_pat #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pat (
    .addr     (cnt_q[ADDR_W-1:0]),
    .mode     (mode_q),
    .fill_val (fill_q),
    .wrdata   (pat_data)
  );

  // Outputs decode registered state; stall gates the strobe directly so the
  // memory port sees no write in a busy cycle.
  assign in_fill = (state_q == FILL);
  assign rdy     = (state_q == IDLE);
  assign done    = (state_q == DONE);
  assign wren    = in_fill & ~stall;
  assign addr    = in_fill ? cnt_q[ADDR_W-1:0] : '0;
  assign wrdata  = in_fill ? pat_data : '0;

endmodule

// File: tb/tb_mem_fill.sv
// Self-checking bench for mem_fill: table-driven fills, randomized fills
// against a pattern model, reset abort, and a reduced-width instance.
module tb_mem_fill;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance
  logic          rst, en, stall, rdy, done, wren;
  logic [1:0]    mode;
  logic [DW-1:0] fill_val, wrdata;
  logic [AW-1:0] addr;

  // Reduced-width instance (ADDR_W=4, DATA_W=3)
  logic       en1, stall1, rdy1, done1, wren1;
  logic [1:0] mode1;
  logic [2:0] fv1, wrdata1;
  logic [3:0] addr1;

  mem_fill #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .fill_val(fill_val),
    .stall(stall), .rdy(rdy), .done(done), .addr(addr), .wrdata(wrdata),
    .wren(wren)
  );

  mem_fill #(.ADDR_W(4), .DATA_W(3)) dut_small (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1), .fill_val(fv1),
    .stall(stall1), .rdy(rdy1), .done(done1), .addr(addr1), .wrdata(wrdata1),
    .wren(wren1)
  );

  int checks = 0;
  int errors = 0;
  int dut_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern rules computed arithmetically from the address.
  function automatic int model_pat(input int m, input int fv, input int a, input int aw, input int dw);
    int v;
    case (m)
      0:       v = a;
      1:       v = (1 << aw) - 1 - a;
      2:       v = fv;
      default: v = a ^ fv;
    endcase
    return v & ((1 << dw) - 1);
  endfunction

  // One fill on the default instance; entered and left at a negedge.
  task automatic run_fill(input logic [1:0] m, input logic [7:0] fv, input int stall_at,
                          input int stall_len, input bit rand_stall, input bit en_noise,
                          input int abort_at, output int n_writes);
    int exp_a = 0;
    int cyc   = 0;
    int wcnt  = 0;
    int scnt  = 0;
    bit s;
    n_writes = 0;
    for (int i = 0; i < DEPTH; i++) dut_mem[i] = -1;
    chk("idle_rdy", rdy, 1);
    chk("idle_wren", wren, 0);
    en = 1'b1; mode = m; fill_val = fv; stall = 1'($urandom);
    @(negedge clk);
    en = 1'b0;
    while (exp_a < DEPTH) begin
      cyc++;
      if (cyc > 4 * DEPTH) begin
        chk("fill_timeout", 32'(exp_a), 32'(DEPTH));
        n_writes = wcnt;
        return;
      end
      mode = 2'($urandom); fill_val = 8'($urandom);
      en = en_noise && (exp_a == 10);
      if (stall_at == exp_a && scnt < stall_len) begin
        s = 1'b1; scnt++;
      end else begin
        s = rand_stall ? ($urandom_range(0, 99) < 30) : 1'b0;
      end
      stall = s;
      #1;
      if (abort_at == exp_a) begin
        rst = 1'b1;
        #1;
        chk("abort_wren", wren, 0);
        chk("abort_rdy", rdy, 1);
        chk("abort_done", done, 0);
        chk("abort_addr", addr, 0);
        chk("abort_wrdata", wrdata, 0);
        @(negedge clk);
        chk("abort_hold_wren", wren, 0);
        chk("abort_hold_done", done, 0);
        rst = 1'b0; stall = 1'b0;
        n_writes = wcnt;
        return;
      end
      chk("fill_rdy", rdy, 0);
      chk("fill_done", done, 0);
      chk("fill_wren", wren, 32'(!s));
      chk("fill_addr", addr, 32'(exp_a));
      chk("fill_wrdata", wrdata, 32'(model_pat(int'(m), int'(fv), exp_a, AW, DW)));
      if (wren === 1'b1) begin
        dut_mem[addr] = int'(wrdata);
        wcnt++;
      end
      if (!s) exp_a++;
      @(negedge clk);
    end
    // DONE cycle: en and stall must both be ignored here
    en = en_noise; stall = 1'($urandom);
    #1;
    chk("done_pulse", done, 1);
    chk("done_wren", wren, 0);
    chk("done_rdy", rdy, 0);
    @(negedge clk);
    en = 1'b0; stall = 1'b0;
    #1;
    chk("post_rdy", rdy, 1);
    chk("post_done", done, 0);
    @(negedge clk);
    chk("no_restart_rdy", rdy, 1);
    chk("write_count", 32'(wcnt), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      chk("mem_word", 32'(dut_mem[i]), 32'(model_pat(int'(m), int'(fv), i, AW, DW)));
    n_writes = wcnt;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] fv;
    int         stall_at;
    int         stall_len;
    bit         en_noise;
    int         probe_addr;
    logic [7:0] probe_exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    vecs[0] = '{2'b00, 8'h00,  -1, 0, 1'b0, 255, 8'hFF};
    vecs[1] = '{2'b01, 8'h00,  -1, 0, 1'b0,   0, 8'hFF};
    vecs[2] = '{2'b01, 8'h00,  -1, 0, 1'b0, 255, 8'h00};
    vecs[3] = '{2'b11, 8'hA5,  -1, 0, 1'b0,   3, 8'hA6};
    vecs[4] = '{2'b10, 8'h3C, 100, 5, 1'b0, 100, 8'h3C};
    vecs[5] = '{2'b00, 8'h00,  -1, 0, 1'b1,  10, 8'h0A};

    rst = 1'b1; en = 1'b0; mode = 2'b11; fill_val = 8'hFF; stall = 1'b1;
    en1 = 1'b0; mode1 = 2'b00; fv1 = 3'd0; stall1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", rdy, 1);
    chk("rst_done", done, 0);
    chk("rst_wren", wren, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wrdata", wrdata, 0);
    rst = 1'b0; stall = 1'b0;

    foreach (vecs[v]) begin
      run_fill(vecs[v].mode, vecs[v].fv, vecs[v].stall_at, vecs[v].stall_len,
               1'b0, vecs[v].en_noise, -1, n);
      chk("probe_word", 32'(dut_mem[vecs[v].probe_addr]), 32'(vecs[v].probe_exp));
    end

    // Reset mid-fill, then an immediate restart from address 0
    run_fill(2'b00, 8'h00, -1, 0, 1'b0, 1'b0, 50, n);
    chk("abort_writes", 32'(n), 32'd50);
    run_fill(2'b11, 8'h5A, -1, 0, 1'b1, 1'b0, -1, n);

    for (int r = 0; r < 4; r++)
      run_fill(2'($urandom), 8'($urandom), -1, 0, 1'b1, 1'($urandom), -1, n);

    // Reduced-width instance: 16 writes, data is addr[2:0]
    chk("small_rdy", rdy1, 1);
    en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("small_wren", wren1, 1);
      chk("small_addr", addr1, 32'(i));
      chk("small_wrdata", wrdata1, 32'(model_pat(0, 0, i, 4, 3)));
      chk("small_done", done1, 0);
      @(negedge clk);
    end
    chk("small_done_pulse", done1, 1);
    chk("small_done_wren", wren1, 0);
    @(negedge clk);
    chk("small_post_rdy", rdy1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
